// File: rtl/sgf_mult_norm_round.sv
// Significand product normalize-and-round stage of the FPU multiply path.
// Two registered stages: 1-bit normalize with guard/sticky, then IEEE round.
module sgf_mult_norm_round #(
    parameter int SW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2*SW-1:0] product_i,
    input  logic            sign_i,
    input  logic [1:0]      rmode_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [SW-1:0]   sgf_o,
    output logic [1:0]      exp_adj_o,
    output logic            sign_o,
    output logic            inexact_o
);

    logic          s1_valid_q, s1_valid_d;
    logic [SW-1:0] s1_m_q, s1_m_d;
    logic          s1_g_q, s1_g_d;
    logic          s1_s_q, s1_s_d;
    logic          s1_n_q, s1_n_d;
    logic          s1_sign_q, s1_sign_d;
    logic [1:0]    s1_rmode_q, s1_rmode_d;

    logic          s2_valid_q, s2_valid_d;
    logic [SW-1:0] s2_sgf_q, s2_sgf_d;
    logic [1:0]    s2_exp_adj_q, s2_exp_adj_d;
    logic          s2_sign_q, s2_sign_d;
    logic          s2_inexact_q, s2_inexact_d;

    logic          s2_adv;
    logic          s1_load;
    logic          inc;
    logic          ovf;
    logic [SW:0]   rnd;

    assign s2_adv  = ~s2_valid_q | ready_i;
    assign ready_o = ~s1_valid_q | s2_adv;
    assign s1_load = ready_o;

    // Stage 1: the product lies in [1,4), so at most a 1-bit right shift.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_m_d     = s1_m_q;
        s1_g_d     = s1_g_q;
        s1_s_d     = s1_s_q;
        s1_n_d     = s1_n_q;
        s1_sign_d  = s1_sign_q;
        s1_rmode_d = s1_rmode_q;
        if (s1_load) begin
            s1_valid_d = valid_i;
            s1_n_d     = product_i[2*SW-1];
            s1_sign_d  = sign_i;
            s1_rmode_d = rmode_i;
            if (product_i[2*SW-1]) begin
                s1_m_d = product_i[2*SW-1:SW];
                s1_g_d = product_i[SW-1];
                s1_s_d = |product_i[SW-2:0];
            end else begin
                s1_m_d = product_i[2*SW-2:SW-1];
                s1_g_d = product_i[SW-2];
                s1_s_d = |product_i[SW-3:0];
            end
        end
    end

    always_comb begin
        inc = 1'b0;
        unique case (s1_rmode_q)
            2'b00: inc = s1_g_q & (s1_s_q | s1_m_q[0]);
            2'b01: inc = 1'b0;
            2'b10: inc = ~s1_sign_q & (s1_g_q | s1_s_q);
            2'b11: inc = s1_sign_q & (s1_g_q | s1_s_q);
        endcase
    end

    assign rnd = {1'b0, s1_m_q} + (SW + 1)'(inc);
    assign ovf = rnd[SW];

    // Stage 2: a carry out of the significand renormalizes to 1.0.
    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_sgf_d     = s2_sgf_q;
        s2_exp_adj_d = s2_exp_adj_q;
        s2_sign_d    = s2_sign_q;
        s2_inexact_d = s2_inexact_q;
        if (s2_adv) begin
            s2_valid_d   = s1_valid_q;
            s2_sgf_d     = ovf ? {1'b1, {(SW - 1){1'b0}}} : rnd[SW-1:0];
            s2_exp_adj_d = {1'b0, s1_n_q} + {1'b0, ovf};
            s2_sign_d    = s1_sign_q;
            s2_inexact_d = s1_g_q | s1_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_m_q       <= '0;
            s1_g_q       <= 1'b0;
            s1_s_q       <= 1'b0;
            s1_n_q       <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_rmode_q   <= 2'b00;
            s2_valid_q   <= 1'b0;
            s2_sgf_q     <= '0;
            s2_exp_adj_q <= 2'b00;
            s2_sign_q    <= 1'b0;
            s2_inexact_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_m_q       <= s1_m_d;
            s1_g_q       <= s1_g_d;
            s1_s_q       <= s1_s_d;
            s1_n_q       <= s1_n_d;
            s1_sign_q    <= s1_sign_d;
            s1_rmode_q   <= s1_rmode_d;
            s2_valid_q   <= s2_valid_d;
            s2_sgf_q     <= s2_sgf_d;
            s2_exp_adj_q <= s2_exp_adj_d;
            s2_sign_q    <= s2_sign_d;
            s2_inexact_q <= s2_inexact_d;
        end
    end

    assign valid_o   = s2_valid_q;
    assign sgf_o     = s2_sgf_q;
    assign exp_adj_o = s2_exp_adj_q;
    assign sign_o    = s2_sign_q;
    assign inexact_o = s2_inexact_q;

endmodule

// File: tb/tb_sgf_mult_norm_round.sv
// Directed bench for sgf_mult_norm_round (SW=24).
// Inputs driven and outputs sampled on the falling edge.
module tb_sgf_mult_norm_round;

    localparam int SW = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_i;
    logic            ready_o;
    logic [2*SW-1:0] product_i;
    logic            sign_i;
    logic [1:0]      rmode_i;
    logic            valid_o;
    logic            ready_i;
    logic [SW-1:0]   sgf_o;
    logic [1:0]      exp_adj_o;
    logic            sign_o;
    logic            inexact_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sgf_mult_norm_round #(.SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .product_i (product_i),
        .sign_i    (sign_i),
        .rmode_i   (rmode_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .sgf_o     (sgf_o),
        .exp_adj_o (exp_adj_o),
        .sign_o    (sign_o),
        .inexact_o (inexact_o)
    );

    // Drives one vector for a single cycle, then waits until its result
    // should be on the outputs (two rising edges after acceptance).
    task automatic send(input logic [2*SW-1:0] p, input logic s,
                        input logic [1:0] rm);
        @(negedge clk);
        valid_i   = 1'b1;
        ready_i   = 1'b1;
        product_i = p;
        sign_i    = s;
        rmode_i   = rm;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        product_i = '0;
        sign_i  = 1'b0;
        rmode_i = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || sgf_o !== '0 || exp_adj_o !== 2'd0 ||
            sign_o !== 1'b0 || inexact_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b sgf=%h adj=%0d s=%b ix=%b want all 0",
                     valid_o, sgf_o, exp_adj_o, sign_o, inexact_o);
        end
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", ready_o);
        end
    endtask

    task automatic test_one_times_one;
        @(negedge clk);
        valid_i   = 1'b1;
        ready_i   = 1'b1;
        product_i = 48'h4000_0000_0000;
        sign_i    = 1'b0;
        rmode_i   = 2'b00;
        @(negedge clk);
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got valid_o=%b want 0", valid_o);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || sgf_o !== 24'h800000 || exp_adj_o !== 2'd0 ||
            inexact_o !== 1'b0) begin
            errors++;
            $display("FAIL one_x_one got v=%b sgf=%h adj=%0d ix=%b want 1 800000 0 0",
                     valid_o, sgf_o, exp_adj_o, inexact_o);
        end
    endtask

    task automatic test_norm_shift;
        send(48'h9000_0000_0000, 1'b1, 2'b00);
        checks++;
        if (valid_o !== 1'b1 || sgf_o !== 24'h900000 || exp_adj_o !== 2'd1 ||
            inexact_o !== 1'b0 || sign_o !== 1'b1) begin
            errors++;
            $display("FAIL norm_shift got v=%b sgf=%h adj=%0d ix=%b s=%b want 1 900000 1 0 1",
                     valid_o, sgf_o, exp_adj_o, inexact_o, sign_o);
        end
    endtask

    task automatic test_round_modes;
        send(48'hFFFF_FE00_0001, 1'b0, 2'b00);
        checks++;
        if (sgf_o !== 24'hFFFFFE || exp_adj_o !== 2'd1 || inexact_o !== 1'b1) begin
            errors++;
            $display("FAIL rne_sticky got sgf=%h adj=%0d ix=%b want fffffe 1 1",
                     sgf_o, exp_adj_o, inexact_o);
        end
        send(48'hFFFF_FE00_0001, 1'b0, 2'b10);
        checks++;
        if (sgf_o !== 24'hFFFFFF || inexact_o !== 1'b1) begin
            errors++;
            $display("FAIL rup_pos got sgf=%h ix=%b want ffffff 1", sgf_o, inexact_o);
        end
        send(48'hFFFF_FE00_0001, 1'b0, 2'b11);
        checks++;
        if (sgf_o !== 24'hFFFFFE) begin
            errors++;
            $display("FAIL rdn_pos got sgf=%h want fffffe", sgf_o);
        end
        send(48'hFFFF_FE00_0001, 1'b1, 2'b11);
        checks++;
        if (sgf_o !== 24'hFFFFFF || sign_o !== 1'b1) begin
            errors++;
            $display("FAIL rdn_neg got sgf=%h s=%b want ffffff 1", sgf_o, sign_o);
        end
        send(48'hFFFF_FE80_0000, 1'b0, 2'b01);
        checks++;
        if (sgf_o !== 24'hFFFFFE || inexact_o !== 1'b1) begin
            errors++;
            $display("FAIL rz got sgf=%h ix=%b want fffffe 1", sgf_o, inexact_o);
        end
        // Exact tie with even LSB stays put under RNE.
        send(48'h8000_0080_0000, 1'b0, 2'b00);
        checks++;
        if (sgf_o !== 24'h800000 || exp_adj_o !== 2'd1 || inexact_o !== 1'b1) begin
            errors++;
            $display("FAIL rne_tie_even got sgf=%h adj=%0d ix=%b want 800000 1 1",
                     sgf_o, exp_adj_o, inexact_o);
        end
    endtask

    task automatic test_round_overflow;
        send(48'h7FFF_FFC0_0000, 1'b0, 2'b00);
        checks++;
        if (sgf_o !== 24'h800000 || exp_adj_o !== 2'd1 || inexact_o !== 1'b1) begin
            errors++;
            $display("FAIL round_ovf got sgf=%h adj=%0d ix=%b want 800000 1 1",
                     sgf_o, exp_adj_o, inexact_o);
        end
        send(48'hFFFF_FF80_0000, 1'b0, 2'b10);
        checks++;
        if (sgf_o !== 24'h800000 || exp_adj_o !== 2'd2) begin
            errors++;
            $display("FAIL round_ovf_adj2 got sgf=%h adj=%0d want 800000 2",
                     sgf_o, exp_adj_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [SW-1:0] m_tab [3];
        m_tab[0] = 24'hA00001;
        m_tab[1] = 24'hB00002;
        m_tab[2] = 24'hC00003;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ready_i = 1'b1;
            if (i >= 2) begin
                checks++;
                if (valid_o !== 1'b1 || sgf_o !== m_tab[i-2] || exp_adj_o !== 2'd1) begin
                    errors++;
                    $display("FAIL b2b_%0d got v=%b sgf=%h adj=%0d want 1 %h 1",
                             i - 2, valid_o, sgf_o, exp_adj_o, m_tab[i-2]);
                end
            end
            if (i < 3) begin
                valid_i   = 1'b1;
                product_i = {m_tab[i], 24'h0};
                rmode_i   = 2'b00;
                sign_i    = 1'b0;
            end else begin
                valid_i = 1'b0;
            end
        end
    endtask

    task automatic test_stream;
        logic [SW-1:0] m_tab [8];
        logic          n_tab [8];
        int            in_idx;
        int            out_idx;
        int            cyc;
        logic          stalled;
        logic [SW-1:0] held_sgf;
        logic [1:0]    held_adj;
        for (int i = 0; i < 8; i++) begin
            m_tab[i] = 24'h800000 | 24'(i * 24'h011111 + 1);
            n_tab[i] = i[0];
        end
        in_idx  = 0;
        out_idx = 0;
        cyc     = 0;
        stalled = 1'b0;
        held_sgf = '0;
        held_adj = '0;
        while (out_idx < 8 && cyc < 300) begin
            @(negedge clk);
            ready_i = (cyc % 3 == 0);
            if (in_idx < 8) begin
                valid_i   = 1'($urandom_range(0, 1));
                product_i = n_tab[in_idx] ? {m_tab[in_idx], 24'h0}
                                          : {1'b0, m_tab[in_idx], 23'h0};
                rmode_i   = 2'b00;
                sign_i    = 1'b0;
            end else begin
                valid_i = 1'b0;
            end
            #1;
            if (stalled) begin
                checks++;
                if (valid_o !== 1'b1 || sgf_o !== held_sgf || exp_adj_o !== held_adj) begin
                    errors++;
                    $display("FAIL stream_stable got v=%b sgf=%h adj=%0d want 1 %h %0d",
                             valid_o, sgf_o, exp_adj_o, held_sgf, held_adj);
                end
            end
            if (ready_o !== 1'b1) begin
                checks++;
                if (!(valid_o === 1'b1 && ready_i === 1'b0)) begin
                    errors++;
                    $display("FAIL stream_ready got ready_o=0 with v=%b rdy_i=%b want v=1 rdy_i=0",
                             valid_o, ready_i);
                end
            end
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                checks++;
                if (sgf_o !== m_tab[out_idx] || exp_adj_o !== {1'b0, n_tab[out_idx]}) begin
                    errors++;
                    $display("FAIL stream_out_%0d got sgf=%h adj=%0d want %h %0d",
                             out_idx, sgf_o, exp_adj_o, m_tab[out_idx], n_tab[out_idx]);
                end
                out_idx++;
            end
            stalled  = (valid_o === 1'b1 && ready_i === 1'b0);
            held_sgf = sgf_o;
            held_adj = exp_adj_o;
            if (valid_i && ready_o === 1'b1) in_idx++;
            cyc++;
        end
        checks++;
        if (out_idx != 8) begin
            errors++;
            $display("FAIL stream_count got %0d outputs want 8", out_idx);
        end
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_dup got valid_o=%b want 0", valid_o);
        end
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        ready_i   = 1'b0;
        valid_i   = 1'b1;
        product_i = 48'hFFFF_FE00_0001;
        rmode_i   = 2'b00;
        sign_i    = 1'b0;
        @(negedge clk);
        product_i = 48'h9000_0000_0000;
        @(negedge clk);
        valid_i = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got v=%b ready_o=%b want 0 1", valid_o, ready_o);
        end
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_stay got valid_o=%b want 0", valid_o);
        end
        send(48'h4000_0000_0000, 1'b0, 2'b00);
        checks++;
        if (valid_o !== 1'b1 || sgf_o !== 24'h800000 || exp_adj_o !== 2'd0) begin
            errors++;
            $display("FAIL post_reset got v=%b sgf=%h adj=%0d want 1 800000 0",
                     valid_o, sgf_o, exp_adj_o);
        end
    endtask

    initial begin
        test_reset();
        test_one_times_one();
        test_norm_shift();
        test_round_modes();
        test_round_overflow();
        test_back_to_back();
        test_stream();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
